vec_serializer: RTL
===================

# vec_serializer

Parametrised, double-buffered vector-to-stream serializer sitting between a parallel-output layer (e.g. a ReLU stage) and the serial input of the next `linear_layer`. It captures a whole `NUM_ELEMS`-element vector in one cycle, optionally applies ReLU at capture, and streams it out `LANES` elements per beat under a valid/ready handshake. A second buffer slot lets the upstream deliver the next vector while the current one drains. Overrun attempts are flagged, never silently merged.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: element width, two's complement.
- `NUM_ELEMS`, default `` `LAYER3_WIDTH ``: elements per vector.
- `LANES`, default 1: elements per output beat. `NUM_ELEMS % LANES == 0`, enforced by elaboration assertion.
- `clk`, input, 1: single clock, all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `i_valid`, input, 1: `din` holds a vector this cycle.
- `i_ready`, output, 1: a free slot exists; accept occurs on `i_valid && i_ready`.
- `din`, input, `[DATA_WIDTH-1:0] [NUM_ELEMS]` (unpacked): parallel input vector.
- `relu_en`, input, 1: apply ReLU to the vector accepted this cycle.
- `o_valid`, output, 1: `dout` holds a beat.
- `o_ready`, input, 1: downstream takes the beat on `o_valid && o_ready`.
- `dout`, output, `[DATA_WIDTH-1:0] [LANES]` (unpacked): current beat; lane k = element `beat*LANES+k`.
- `o_last`, output, 1: current beat is the final beat of its vector.
- `o_beat`, output, `BW` bits: index of the current beat.
- `o_overflow`, output, 1: sticky; set on `i_valid && !i_ready`.

## Operation
- `BEATS = NUM_ELEMS/LANES`.
- `BW = max(1, $clog2(BEATS))`. The beat counter must hold `BEATS-1` and is compared against `BEATS-1`, never `BEATS`.
- State:
  - two slots;
  - `wr_ptr`, `rd_ptr` (1 bit each);
  - `count` (0..2);
  - `beat` (`BW` bits).
- Derived states:
  - EMPTY: `count==0`.
  - DRAIN: `count==1`.
  - FULL: `count==2`.
- `i_ready = (count != 2)`. It comes from registered state only, so there is no combinational path from `o_ready` to `i_ready`.
- Accept:
  - Slot `wr_ptr` is written with `din`. When `relu_en=1`, each element with MSB=1 is written as 0.
  - `wr_ptr` toggles. `relu_en` is sampled only on accept.
- `o_valid = (count != 0)`.
- `dout` is the slice `beat` of slot `rd_ptr`, forced to 0 when `o_valid=0`.
- `o_last = o_valid && (beat == BEATS-1)`.
- Pop (`o_valid && o_ready`):
  - Not last: `beat` increments.
  - Last: `beat` clears to 0, `rd_ptr` toggles, and the vector retires.
- Count update:
  - accept without retire: `count+1`;
  - retire without accept: `count-1`;
  - both in the same cycle: unchanged. Legal only from DRAIN, since FULL blocks accept.
- `o_ready` held low: `dout`, `o_beat` and `o_last` hold stable (AXI-style; no retraction while `o_valid`).
- Overrun (`i_valid && !i_ready`): `din` is discarded, stored data is untouched, and `o_overflow` is set from the next cycle until `rst`.
- `BEATS==1`: every beat is last; the beat counter is constant 0.

## Timing
- Reset values after `rst` is high on an edge:
  - `count=0`, `beat=0`, `wr_ptr=rd_ptr=0`;
  - `i_ready=1`, `o_valid=0`, `o_last=0`, `o_beat=0`, `dout=0`, `o_overflow=0`.
- Reset mid-stream discards both slots; the partially sent vector is not completed. `rst` dominates simultaneous accept and pop.
- Latency: a vector accepted at edge N presents beat 0 at cycle N+1.
- Throughput: one beat per cycle with `o_ready=1`.
- Sustained input rate: one vector per `BEATS` cycles without overflow.
- From FULL, `i_ready` rises in the cycle after the retiring pop.

## Structure
- `vec_serializer_pkg`:
  - `clog2_min1()` width helper;
  - `relu_elem()` function (parametrised via a `DATA_WIDTH`-typed class-free function argument width; signed MSB test).
  - The `EMPTY`/`DRAIN`/`FULL` encodings live there as an enum for assertions and waveform readability.
- One sub-module, `relu_vec`: combinational, `NUM_ELEMS`-wide, `enable` input. It feeds the slot write port.
- Slots are unpacked register arrays in `vec_serializer`; no RAM inference.

## Test plan
Default configuration unless stated: `DATA_WIDTH=8`, `NUM_ELEMS=4`, `LANES=2`.

- **Reset + basic stream:** after `rst`, accept `din={5,-3,7,1}`, `relu_en=0`, `o_ready=1` → beats `{5,-3}` then `{7,1}` at cycles N+1 and N+2; `o_last=0` then 1; `o_valid=0` at N+3.
- **ReLU at capture:** same vector with `relu_en=1` → `{5,0}`, `{7,1}`. Toggling `relu_en` after the accept does not change the output.
- **Backpressure / double buffer:** hold `o_ready=0`, accept A then B → `count=2`, `i_ready=0`; a third `i_valid` sets `o_overflow=1` and A and B are intact. Release `o_ready` → A's two beats then B's, with `i_ready=1` the cycle after A's last beat.
- **Simultaneous retire + accept:** in DRAIN, accept C on the same edge as A's last beat → `count` stays 1 and C streams immediately after A with no bubble.
- **`LANES=1`, `NUM_ELEMS=3`:** `o_beat` runs 0, 1, 2 and wraps to 0, and `o_last` is asserted only at 2. This confirms the counter compare uses `BEATS-1`.
- **Mid-stream reset:** `rst` during beat 0 with both slots full → next cycle `o_valid=0`, `i_ready=1`, `o_overflow=0`, and no stale beat appears afterward.

Source files
------------

// File: rtl/vec_serializer_pkg.sv
// ---------------------------------------------------------------------------
// vec_serializer_pkg
//
// Shared definitions for the vector serializer:
//   - default element width / vector length macros (used when the including
//     build does not provide its own network-wide values)
//   - occ_e      : buffer occupancy encoding (EMPTY / DRAIN / FULL)
//   - clog2_min1 : width helper that never returns 0
//   - relu_elem  : width-agnostic ReLU on a single two's complement element
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef LAYER3_WIDTH
`define LAYER3_WIDTH 4
`endif

package vec_serializer_pkg;

  // Widest element relu_elem can handle; elements are zero-extended into
  // this container so one function serves every DATA_WIDTH.
  localparam int RELU_MAX_W = 64;

  // Occupancy of the two-slot buffer. The value doubles as the number of
  // stored vectors, so 2'd3 is never legal.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // Counter width that is at least 1 bit even when only one value is needed.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // ReLU on one element of 'width' bits held in the low bits of x: a set
  // sign bit (bit width-1) means negative, which clamps to zero.
  function automatic logic [RELU_MAX_W-1:0] relu_elem(
    input logic [RELU_MAX_W-1:0] x,
    input int                    width
  );
    logic [RELU_MAX_W-1:0] sign_sh;
    sign_sh = x >> (width - 1);
    if (sign_sh[0]) begin
      return '0;
    end
    return x;
  endfunction

endpackage

// File: rtl/vec_serializer_relu_vec.sv
// ---------------------------------------------------------------------------
// relu_vec
//
// Purely combinational ReLU over a whole vector. With enable low the vector
// passes through untouched; with enable high every negative element becomes 0.
//
// Ports:
//   enable : apply ReLU to this vector
//   din    : input vector, NUM_ELEMS elements of DATA_WIDTH bits
//   dout   : output vector, same shape as din
// ---------------------------------------------------------------------------
module relu_vec
  import vec_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 4
) (
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din  [NUM_ELEMS],
  output logic [DATA_WIDTH-1:0] dout [NUM_ELEMS]
);

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_elem
    logic [RELU_MAX_W-1:0] clamped;

    assign clamped = relu_elem(RELU_MAX_W'(din[g]), DATA_WIDTH);
    assign dout[g] = enable ? clamped[DATA_WIDTH-1:0] : din[g];
  end

endmodule

// File: rtl/vec_serializer.sv
// ---------------------------------------------------------------------------
// vec_serializer
//
// Double-buffered vector-to-stream serializer. A whole NUM_ELEMS vector is
// captured in one cycle (optionally through ReLU) and streamed out LANES
// elements per beat with valid/ready handshakes on both sides. Two slots let
// the next vector arrive while the current one drains; an attempt to write
// while both slots are occupied is dropped and flagged on a sticky bit.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_valid    : din carries a vector this cycle
//   i_ready    : a slot is free (accept on i_valid && i_ready)
//   din        : parallel input vector, NUM_ELEMS x DATA_WIDTH
//   relu_en    : clamp negatives of the vector accepted this cycle
//   o_valid    : dout carries a beat
//   o_ready    : downstream takes the beat (pop on o_valid && o_ready)
//   dout       : current beat, lane k = element beat*LANES+k
//   o_last     : current beat is the last of its vector
//   o_beat     : index of the current beat
//   o_overflow : sticky flag for writes attempted while full
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef LAYER3_WIDTH
`define LAYER3_WIDTH 4
`endif

module vec_serializer
  import vec_serializer_pkg::*;
#(
  parameter  int DATA_WIDTH = `DATA_WIDTH,
  parameter  int NUM_ELEMS  = `LAYER3_WIDTH,
  parameter  int LANES      = 1,
  localparam int BEATS      = NUM_ELEMS / LANES,
  localparam int BW         = clog2_min1(NUM_ELEMS / LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] din [NUM_ELEMS],
  input  logic                  relu_en,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] dout [LANES],
  output logic                  o_last,
  output logic [BW-1:0]         o_beat,
  output logic                  o_overflow
);

  // A partial final beat would need lane masking, which this block does not
  // provide, so refuse such configurations at elaboration.
  if (LANES < 1 || (NUM_ELEMS % LANES) != 0) begin : g_bad_lanes
    $error("vec_serializer: NUM_ELEMS (%0d) must be a multiple of LANES (%0d)",
           NUM_ELEMS, LANES);
  end
  if (DATA_WIDTH > RELU_MAX_W) begin : g_bad_width
    $error("vec_serializer: DATA_WIDTH (%0d) exceeds %0d", DATA_WIDTH, RELU_MAX_W);
  end

  // Element index width inside a slot.
  localparam int            IW        = clog2_min1(NUM_ELEMS);
  // The counter tops out at BEATS-1, never BEATS, so BW bits always suffice.
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  occ_e                  state_q,    state_d;
  logic                  wr_ptr_q,   wr_ptr_d;
  logic                  rd_ptr_q,   rd_ptr_d;
  logic [BW-1:0]         beat_q,     beat_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] slot_q [2][NUM_ELEMS];
  logic [DATA_WIDTH-1:0] slot_d [2][NUM_ELEMS];

  logic [DATA_WIDTH-1:0] relu_out [NUM_ELEMS];
  logic                  accept;
  logic                  pop;
  logic                  at_last;
  logic                  retire;

  relu_vec #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ELEMS  (NUM_ELEMS)
  ) u_relu (
    .enable (relu_en),
    .din    (din),
    .dout   (relu_out)
  );

  // Handshake qualifiers. Both ready and valid come from registered state
  // only, so o_ready never reaches i_ready combinationally.
  assign i_ready    = (state_q != FULL);
  assign o_valid    = (state_q != EMPTY);
  assign at_last    = (beat_q == LAST_BEAT);
  assign o_last     = o_valid && at_last;
  assign o_beat     = beat_q;
  assign o_overflow = overflow_q;

  assign accept = i_valid && i_ready;
  assign pop    = o_valid && o_ready;
  assign retire = pop && at_last;

  // Next-state logic: pointer/beat advance and occupancy tracking. An accept
  // and a retire on the same edge cancel out, which keeps a DRAIN buffer in
  // DRAIN and lets the new vector follow with no bubble.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    overflow_d = overflow_q | (i_valid & ~i_ready);

    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      if (at_last) begin
        beat_d   = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    case ({accept, retire})
      2'b10: begin
        case (state_q)
          EMPTY:   state_d = DRAIN;
          DRAIN:   state_d = FULL;
          default: state_d = state_q;
        endcase
      end
      2'b01: begin
        case (state_q)
          FULL:    state_d = DRAIN;
          DRAIN:   state_d = EMPTY;
          default: state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  // Control registers. Reset wins over any accept or pop on the same edge and
  // leaves both slots logically empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Slot write port: only the slot under wr_ptr changes, and only on accept.
  // Overrun data never gets here because accept requires i_ready.
  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d[wr_ptr_q] = relu_out;
    end
  end

  // Slot storage needs no reset: occupancy decides whether it is visible.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  // Output beat mux: slice 'beat' of the slot being read, zero when idle so
  // stale data never leaks downstream.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      dout[k] = '0;
      if (o_valid) begin
        dout[k] = slot_q[rd_ptr_q][IW'(int'(beat_q) * LANES + k)];
      end
    end
  end

  // Occupancy must always be one of the three legal encodings.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (state_q inside {EMPTY, DRAIN, FULL})
        else $error("vec_serializer: illegal occupancy %0d", state_q);
    end
  end

endmodule
